// File: rtl/carpma_hakemi_pkg.sv
// Shared codes for the multiplier arbiter: operation encodings, owner tags and
// the per-stage tracking record.
package carpma_hakemi_pkg;

  localparam logic [1:0] CARPMA_MUL    = 2'b00;
  localparam logic [1:0] CARPMA_MULH   = 2'b01;
  localparam logic [1:0] CARPMA_MULHSU = 2'b10;
  localparam logic [1:0] CARPMA_MULHU  = 2'b11;

  localparam logic HAKEM_SAHIP0 = 1'b0;
  localparam logic HAKEM_SAHIP1 = 1'b1;

  typedef struct packed {
    logic gecerli;
    logic sahip;
  } izleme_t;

endpackage

// File: rtl/carpma_izleyici.sv
// Tracks which port owns each operation inside the multiplier pipeline.
// Shifts in lockstep with the multiplier and freezes with it on a hold.
module carpma_izleyici
  import carpma_hakemi_pkg::*;
#(
  parameter int unsigned GECIKME = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tutma_i,
  input  logic yukle_gecerli_i,
  input  logic yukle_sahip_i,
  output logic bas_gecerli_o,
  output logic bas_sahip_o,
  output logic herhangi_o
);

  izleme_t r_asama [GECIKME];

  genvar gi;
  generate
    for (gi = 0; gi < GECIKME; gi++) begin : g_asama
      if (gi == 0) begin : g_ilk
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            r_asama[gi] <= '0;
          end else if (!tutma_i) begin
            r_asama[gi] <= '{gecerli: yukle_gecerli_i, sahip: yukle_sahip_i};
          end
        end
      end else begin : g_sonraki
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            r_asama[gi] <= '0;
          end else if (!tutma_i) begin
            r_asama[gi] <= r_asama[gi-1];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    herhangi_o = 1'b0;
    for (int i = 0; i < GECIKME; i++) begin
      herhangi_o = herhangi_o | r_asama[i].gecerli;
    end
  end

  assign bas_gecerli_o = r_asama[GECIKME-1].gecerli;
  assign bas_sahip_o   = r_asama[GECIKME-1].sahip;

endmodule

// File: rtl/carpma_hakemi.sv
// Round-robin arbiter sharing one multiplier between two requesters; results
// return to their owner after the pipeline latency, stalling on backpressure.
module carpma_hakemi
  import carpma_hakemi_pkg::*;
#(
  parameter int unsigned GECIKME = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        istek0_gecerli_i,
  output logic        istek0_hazir_o,
  input  logic [1:0]  istek0_kontrol_i,
  input  logic [31:0] istek0_deger1_i,
  input  logic [31:0] istek0_deger2_i,
  output logic        sonuc0_gecerli_o,
  input  logic        sonuc0_hazir_i,
  output logic [31:0] sonuc0_o,
  input  logic        istek1_gecerli_i,
  output logic        istek1_hazir_o,
  input  logic [1:0]  istek1_kontrol_i,
  input  logic [31:0] istek1_deger1_i,
  input  logic [31:0] istek1_deger2_i,
  output logic        sonuc1_gecerli_o,
  input  logic        sonuc1_hazir_i,
  output logic [31:0] sonuc1_o,
  output logic        carp_durdur_o,
  output logic [1:0]  carp_kontrol_o,
  output logic [31:0] carp_deger1_o,
  output logic [31:0] carp_deger2_o,
  input  logic [31:0] carp_sonuc_i,
  output logic        mesgul_o
);

  logic w_bas_gecerli;
  logic w_bas_sahip;
  logic w_herhangi;
  logic w_durdur;
  logic w_verildi;
  logic w_kazanan;
  logic r_son_verilen;

  assign w_durdur = w_bas_gecerli &
                    ~((w_bas_sahip == HAKEM_SAHIP1) ? sonuc1_hazir_i : sonuc0_hazir_i);

  // Grants are masked during reset so no handshake completes while it is held.
  always_comb begin
    w_verildi = 1'b0;
    w_kazanan = HAKEM_SAHIP0;
    if (!w_durdur && !rst_i) begin
      if (istek0_gecerli_i && istek1_gecerli_i) begin
        w_verildi = 1'b1;
        w_kazanan = ~r_son_verilen;
      end else if (istek0_gecerli_i) begin
        w_verildi = 1'b1;
        w_kazanan = HAKEM_SAHIP0;
      end else if (istek1_gecerli_i) begin
        w_verildi = 1'b1;
        w_kazanan = HAKEM_SAHIP1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_son_verilen <= HAKEM_SAHIP1;
    end else if (w_verildi) begin
      r_son_verilen <= w_kazanan;
    end
  end

  // Idle cycles feed zeros so the multiplier's internal state stays deterministic.
  always_comb begin
    carp_kontrol_o = CARPMA_MUL;
    carp_deger1_o  = '0;
    carp_deger2_o  = '0;
    if (w_verildi) begin
      if (w_kazanan == HAKEM_SAHIP1) begin
        carp_kontrol_o = istek1_kontrol_i;
        carp_deger1_o  = istek1_deger1_i;
        carp_deger2_o  = istek1_deger2_i;
      end else begin
        carp_kontrol_o = istek0_kontrol_i;
        carp_deger1_o  = istek0_deger1_i;
        carp_deger2_o  = istek0_deger2_i;
      end
    end
  end

  carpma_izleyici #(
    .GECIKME(GECIKME)
  ) u_izleyici (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .tutma_i        (w_durdur),
    .yukle_gecerli_i(w_verildi),
    .yukle_sahip_i  (w_kazanan),
    .bas_gecerli_o  (w_bas_gecerli),
    .bas_sahip_o    (w_bas_sahip),
    .herhangi_o     (w_herhangi)
  );

  assign istek0_hazir_o   = w_verildi & (w_kazanan == HAKEM_SAHIP0);
  assign istek1_hazir_o   = w_verildi & (w_kazanan == HAKEM_SAHIP1);
  assign sonuc0_gecerli_o = w_bas_gecerli & (w_bas_sahip == HAKEM_SAHIP0);
  assign sonuc1_gecerli_o = w_bas_gecerli & (w_bas_sahip == HAKEM_SAHIP1);
  assign sonuc0_o         = carp_sonuc_i;
  assign sonuc1_o         = carp_sonuc_i;
  assign carp_durdur_o    = w_durdur;
  assign mesgul_o         = w_herhangi;

endmodule

// File: doc/carpma_hakemi.md
Name: carpma_hakemi

Overview:
Two-port round-robin arbiter and sequencer that shares one carpma_birimi between two requesters: the execute stage (port 0) and an auxiliary unit (port 1). It accepts requests through valid/ready handshakes and tracks in-flight operations with an owner tag. Each result is returned to its owner after a fixed pipeline latency. When an owner is not ready to take its result, the block freezes the multiplier through its stall input.

Parameters:
GECIKME, 1, multiplier latency in cycles from operand issue to valid sonuc_o (1 = FPGA path; 1..4 supported)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
istek0_gecerli_i  input  1  port 0 request valid
istek0_hazir_o  output  1  port 0 request accepted this cycle
istek0_kontrol_i  input  2  port 0 op (CARPMA_MUL/MULH/MULHU/MULHSU)
istek0_deger1_i  input  32  port 0 operand 1
istek0_deger2_i  input  32  port 0 operand 2
sonuc0_gecerli_o  output  1  port 0 result valid
sonuc0_hazir_i  input  1  port 0 result accept
sonuc0_o  output  32  port 0 result
istek1_* / sonuc1_*  same set for port 1
carp_durdur_o  output  1  to carpma_birimi durdur_i
carp_kontrol_o  output  2  to carpma_birimi kontrol_i
carp_deger1_o  output  32  to carpma_birimi deger1_i
carp_deger2_o  output  32  to carpma_birimi deger2_i
carp_sonuc_i  input  32  from carpma_birimi sonuc_o
mesgul_o  output  1  any operation in flight

Behaviour:
Tracking pipe:
- GECIKME stages; each stage holds {gecerli, sahip}. Stage 0 is written on issue; the last stage is the "head".
- durdur = head.gecerli & ~sonucX_hazir_i, where X = head.sahip.
- carp_durdur_o = durdur. While durdur=1, the whole pipe and the multiplier hold.
- When durdur=0, the pipe shifts each cycle. Stage 0 loads {issued, grant_id}.

Result path (combinational):
- sonucX_gecerli_o = head.gecerli & (head.sahip == X).
- sonuc0_o and sonuc1_o are both driven from carp_sonuc_i. Only the valid one is meaningful.

Issue and arbitration:
- The grant is computed only when durdur=0. At most one grant per cycle.
- istekX_hazir_o = grant==X & ~durdur.
- Only one port valid: that port wins.
- Both ports valid: the port other than son_verilen wins. son_verilen updates on every accepted grant.
- The winner's kontrol and operands drive the carp_* outputs.
- No grant: carp_deger1_o = carp_deger2_o = 0 and carp_kontrol_o = CARPMA_MUL, so the accumulator path stays deterministic.

Throughput and latency:
- Full throughput: a result can be accepted and a new request issued in the same cycle.
- Request accepted at cycle T with no stall gives result valid at T+GECIKME.
- Each cycle of durdur adds exactly one cycle of latency to every in-flight operation.
- Ordering is preserved both per port and globally.

Reset:
- Async assertion clears all stage valids. son_verilen = 1, so port 0 wins first.
- Reset mid-operation discards in-flight results. No sonuc valid appears after reset.
- Reset output values: hazir 0, sonuc valid 0, carp_durdur_o 0, mesgul_o 0.

Misc:
- mesgul_o = OR of all stage valids.
- Ready never depends on the same port's sonuc_hazir_i other than through durdur; no combinational loop with carpma_birimi.

Decomposition:
- tanimlamalar.vh: the existing CARPMA_* codes, plus HAKEM_SAHIP0 = 1'b0 and HAKEM_SAHIP1 = 1'b1.
- Sub-module carpma_izleyici holds the GECIKME-deep {gecerli, sahip} shift pipe with hold input, head outputs and any-valid output.
- The top level contains the round-robin logic and the muxes.

Test Plan:
- Single op, GECIKME=1: port 0 MUL 7*6 at T, sonuc0_hazir=1 -> istek0_hazir_o=1 at T, sonuc0_gecerli_o=1 with 42 at T+1, port 1 silent.
- Signed/unsigned high: port 1 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- Contention: both valid for 4 cycles after reset -> grants 0,1,0,1, results returned in that order to the correct ports, one per cycle.
- Backpressure: port 0 result pending with sonuc0_hazir=0 for 3 cycles -> carp_durdur_o=1 for 3 cycles, no issues, result value held stable, then accepted.
- Back-to-back throughput, GECIKME=3: 8 port 0 MULs (i*i for i=1..8) -> 8 results 1..64 on 8 consecutive cycles starting at issue+3.
- Async reset mid-flight: assert rst_i between clock edges with 2 ops in flight -> all outputs zero immediately; no stale result after release; first grant goes to port 0.
